// File: rtl/pc_plus_adder_pkg.sv
// Shared address-width constant, address type and default reset vector
// for the fetch-stage program counter.
package pc_plus_adder_pkg;

  localparam int unsigned ADDR_WIDTH = 32;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam addr_t DEFAULT_RESET_PC = '0;

endpackage

// File: rtl/pc_plus_adder_pc_incrementer.sv
// Combinational pc + STEP adder. It returns the wrapped sum and the carry
// out of the top bit.
module pc_incrementer #(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] STEP  = WIDTH'(1)
) (
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // One extra bit catches the overflow past 2^WIDTH-1.
  logic [WIDTH:0] full_sum;

  assign full_sum = {1'b0, pc} + {1'b0, STEP};
  assign sum      = full_sum[WIDTH-1:0];
  assign carry    = full_sum[WIDTH];

endmodule

// File: rtl/pc_plus_adder.sv
// Program counter with built-in incrementer. Update priority is load, then
// enable, then hold. wrap pulses for one cycle after an overflowing increment.
module pc_plus_adder
  import pc_plus_adder_pkg::*;
#(
  parameter int unsigned      WIDTH    = ADDR_WIDTH,
  parameter logic [WIDTH-1:0] STEP     = WIDTH'(1),
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_pc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             wrap
);

  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] pc_next;
  logic             wrap_reg;
  logic             wrap_next;
  logic [WIDTH-1:0] inc_sum;
  logic             inc_carry;

  pc_incrementer #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_pc_incrementer (
    .pc    (pc_reg),
    .sum   (inc_sum),
    .carry (inc_carry)
  );

  // A load never reports a wrap, even when enable is also high.
  always_comb begin
    pc_next   = pc_reg;
    wrap_next = 1'b0;
    if (load) begin
      pc_next = load_pc;
    end else if (enable) begin
      pc_next   = inc_sum;
      wrap_next = inc_carry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg   <= RESET_PC;
      wrap_reg <= 1'b0;
    end else begin
      pc_reg   <= pc_next;
      wrap_reg <= wrap_next;
    end
  end

  assign pc      = pc_reg;
  assign pc_plus = inc_sum;
  assign wrap    = wrap_reg;

endmodule

// File: tb/tb_pc_plus_adder.sv
// Directed bench for pc_plus_adder. Inputs change on the falling edge, and
// outputs are checked there or at fixed offsets between edges.
module tb_pc_plus_adder;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        load;
  logic [31:0] load_pc;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic        wrap;

  int checks;
  int passes;

  pc_plus_adder #(
    .WIDTH    (32),
    .STEP     (32'd1),
    .RESET_PC (32'd0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .load    (load),
    .load_pc (load_pc),
    .pc      (pc),
    .pc_plus (pc_plus),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) begin
      passes++;
      $display("check %-14s observed=%h expected=%h", tag, observed, expected);
    end else begin
      $error("FAIL %s: observed=%h required=%h", tag, observed, expected);
    end
  endtask

  initial begin
    checks  = 0;
    passes  = 0;
    rst     = 1'b0;
    enable  = 1'b0;
    load    = 1'b0;
    load_pc = 32'h0;

    // Reset held
    #10;
    check("rst_pc", pc, 32'h0);
    check("rst_wrap", {31'b0, wrap}, 32'h0);
    check("rst_pc_plus", pc_plus, 32'h1);

    // Count three enabled edges
    @(negedge clk);
    rst    = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("count_pc", pc, 32'h3);
    check("count_pc_plus", pc_plus, 32'h4);
    check("count_wrap", {31'b0, wrap}, 32'h0);

    // Hold for two edges
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("hold_pc", pc, 32'h3);
    check("hold_wrap", {31'b0, wrap}, 32'h0);

    // Async reset between edges, enable high to prove reset dominates
    enable = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("async_pc", pc, 32'h0);
    @(negedge clk);
    check("async_hold_pc", pc, 32'h0);
    check("async_pc_plus", pc_plus, 32'h1);

    // Restart counting from reset vector
    rst = 1'b1;
    @(negedge clk);
    check("restart_pc", pc, 32'h1);

    // Load priority over enable
    load    = 1'b1;
    load_pc = 32'h100;
    @(negedge clk);
    check("load_pc", pc, 32'h100);
    load = 1'b0;
    @(negedge clk);
    check("load_inc_pc", pc, 32'h101);
    check("load_inc_plus", pc_plus, 32'h102);

    // Load with enable at the top address: no increment, no wrap
    load    = 1'b1;
    load_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    check("top_pc", pc, 32'hFFFF_FFFF);
    check("top_pc_plus", pc_plus, 32'h0);
    @(negedge clk);
    check("top_reload_pc", pc, 32'hFFFF_FFFF);
    check("top_reload_wrap", {31'b0, wrap}, 32'h0);

    // Overflowing increment
    load = 1'b0;
    @(negedge clk);
    check("wrap_pc", pc, 32'h0);
    check("wrap_pulse", {31'b0, wrap}, 32'h1);
    @(negedge clk);
    check("post_wrap_pc", pc, 32'h1);
    check("post_wrap_flag", {31'b0, wrap}, 32'h0);

    // wrap also drops when holding after an overflow
    load = 1'b1;
    load_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    check("wrap2_pulse", {31'b0, wrap}, 32'h1);
    enable = 1'b0;
    @(negedge clk);
    check("hold_clr_wrap", {31'b0, wrap}, 32'h0);
    check("hold_clr_pc", pc, 32'h0);

    // Async reset clears a live wrap pulse
    load_pc = 32'hFFFF_FFFF;
    load    = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    check("wrap3_pulse", {31'b0, wrap}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("rst_clr_wrap", {31'b0, wrap}, 32'h0);
    check("rst_clr_pc", pc, 32'h0);
    @(negedge clk);
    rst    = 1'b1;
    enable = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
